led_fader: RTL
==============

// Module: led_fader
// PURPOSE
// - Downstream stage of the LED trail shifter: takes its 4-bit on/off pattern, drives the board LEDs with PWM.
// - Each lit channel jumps to full brightness, then decays linearly once its input bit drops.
// - Result: the moving dot leaves a fading tail. Sits between the pattern generator and the LED pins.
// PARAMETERS
// - PWM_BITS   8      width of PWM counter and per-channel brightness level; period = 2**PWM_BITS clk
// - DECAY_DIV  65536  clk cycles per decay tick (>=2); each tick lowers every non-held level by 1
// - CHANNELS   4      number of LED channels
// PORTS
// - clk      in   1         system clock; all logic on posedge clk
// - rst      in   1         synchronous, active-high reset
// - pattern  in   CHANNELS  on/off pattern from the trail stage, synchronous to clk
// - led_out  out  CHANNELS  PWM LED drive, registered, active-high
// - active   out  1         high while any channel level is non-zero, registered
// BEHAVIOUR
// - One clock domain; reset synchronous, active-high. No other reset.
// - On a rst cycle, next edge clears all of:
//   - pwm_cnt, prescaler, every level[i], led_out, active.
// - pwm_cnt: PWM_BITS-wide free-running up-counter, +1 every cycle, wraps 2**PWM_BITS-1 -> 0.
// - prescaler: counts 0..DECAY_DIV-1, then wraps to 0.
//   - tick is combinational, high in the cycle prescaler == DECAY_DIV-1.
// - Per channel i, level[i] (PWM_BITS wide) updates each edge, in priority order:
//   1. pattern[i]==1 -> level[i] <= MAX (2**PWM_BITS-1), whether or not tick is high.
//   2. tick && level[i]!=0 -> level[i] <= level[i]-1.
//   3. else hold. Saturates at 0; never wraps below 0.
// - led_out[i] <= (pwm_cnt < level[i]), using current registered values. Latency:
//   - pattern -> level: 1 clk.
//   - level -> led_out: 1 clk.
// - Duty: level L gives exactly L high cycles per 2**PWM_BITS-cycle period.
//   - L=0 never lit; L=MAX lit for all but 1 cycle of the period.
// - active <= OR of (level[i]!=0) over all channels; 1 clk after the levels.
// - Channels are independent; a held-high pattern bit pins that channel at MAX indefinitely.
// - Rst mid-fade: all levels drop to 0 immediately; pwm_cnt and prescaler restart from 0.
//   - Any pattern bit high on the first post-reset cycle reloads MAX normally.
// - pattern is not resynchronised; it must come from the same clk domain.
// TESTING (bench with PWM_BITS=4, DECAY_DIV=4, CHANNELS=4)
// - Reset: rst high 2 cycles, pattern=0000 -> led_out=0000, active=0, all levels 0, pwm_cnt=0 after release.
// - Single pulse: pattern=0001 for 1 cycle, then 0000.
//   -> level[0]=15 one cycle later; active=1.
//   -> level[0] drops by 1 every 4 cycles; reaches 0 after 60 cycles; active=0 one cycle after that.
// - Duty check: freeze level[0] at 6 via pattern timing; count led_out[0] over 16 cycles -> exactly 6 high.
//   - Level 15 -> 15 high; level 0 -> 0 high.
// - Hold: pattern=1000 held 200 cycles -> level[3] stays 15 across all ticks; channels 0-2 stay 0.
// - Collision/saturation:
//   - pattern[1] rises in a tick cycle -> level[1]=15, not 14.
//   - Channel at level 0 through 10 ticks -> stays 0, no wrap to 15.
// - Mid-fade reset: pattern=1111 pulse, wait 20 cycles, assert rst 1 cycle.
//   -> all levels and led_out 0 next cycle; active=0.
//   -> pattern=0100 right after release reloads level[2]=15.

Source files
------------

// File: rtl/led_fader.sv
// rtl/led_fader.sv - PWM LED driver where each channel snaps to full brightness and decays linearly
// Levels reload on a lit pattern bit, then lose one step per prescaler tick down to zero.
module led_fader #(
    parameter int PWM_BITS  = 8,
    parameter int DECAY_DIV = 65536,
    parameter int CHANNELS  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] pattern,
    output logic [CHANNELS-1:0] led_out,
    output logic                active
);
    localparam int                  PS_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [PWM_BITS-1:0] LVL_MAX = {PWM_BITS{1'b1}};
    localparam logic [PS_W-1:0]     PS_LAST = PS_W'(DECAY_DIV - 1);

    logic [PWM_BITS-1:0]               r_pwm_cnt;
    logic [PS_W-1:0]                   r_prescaler;
    logic [CHANNELS-1:0][PWM_BITS-1:0] r_level;
    logic [CHANNELS-1:0]               r_led_out;
    logic                              r_active;

    logic                              w_tick;
    logic [CHANNELS-1:0][PWM_BITS-1:0] w_level_nxt;
    logic [CHANNELS-1:0]               w_led_nxt;
    logic                              w_any_lit;

    assign w_tick = (r_prescaler == PS_LAST);

    // A high pattern bit outranks a coincident decay tick; decay saturates at zero.
    always_comb begin
        w_level_nxt = r_level;
        w_led_nxt   = '0;
        w_any_lit   = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (pattern[i]) begin
                w_level_nxt[i] = LVL_MAX;
            end else if (w_tick && (r_level[i] != '0)) begin
                w_level_nxt[i] = r_level[i] - 1'b1;
            end
            w_led_nxt[i] = (r_pwm_cnt < r_level[i]);
            if (r_level[i] != '0) begin
                w_any_lit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt   <= '0;
            r_prescaler <= '0;
            r_level     <= '0;
            r_led_out   <= '0;
            r_active    <= 1'b0;
        end else begin
            r_pwm_cnt   <= r_pwm_cnt + 1'b1;
            r_prescaler <= w_tick ? '0 : r_prescaler + 1'b1;
            r_level     <= w_level_nxt;
            r_led_out   <= w_led_nxt;
            r_active    <= w_any_lit;
        end
    end

    assign led_out = r_led_out;
    assign active  = r_active;

endmodule
